// File: rtl/data_mem_responder.sv
// Byte-addressable 512-byte data memory: aligned loads return after 1 cycle, word-straddling loads after 2.
// No ready handshake: busy is high for one cycle during a straddling access, and requests made while busy are dropped.
module data_mem_responder #(
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [8:0]        addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mem [DEPTH_W];

  logic        accept;
  logic        split_cur;
  logic [6:0]  k_cur;
  logic [7:0]  mask_cur;
  logic [63:0] wdat64_cur;
  logic [31:0] rd_cur;
  logic [31:0] rd_split;

  // Second-half context, captured when a straddling access is accepted
  logic [6:0]  k1_q;
  logic [1:0]  off_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdat_hi_q;
  logic [3:0]  mask_hi_q;
  logic        wr_q;
  logic        rd_only_q;
  logic [31:0] lo_q;
  logic [31:0] rd_data_q;

  // Byte lanes touched across the two-word window {word k+1, word k}
  function automatic logic [7:0] lane_mask(input logic [2:0] f, input logic [1:0] off);
    logic [7:0] base;
    case (f[1:0])
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

  function automatic logic [31:0] window(input logic [63:0] w, input logic [1:0] off);
    return w[{off, 3'b000} +: 32];
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] r, input logic [2:0] f);
    case (f)
      3'b000:  return {{24{r[7]}}, r[7:0]};
      3'b001:  return {{16{r[15]}}, r[15:0]};
      3'b100:  return {24'b0, r[7:0]};
      3'b101:  return {16'b0, r[15:0]};
      default: return r;
    endcase
  endfunction

  assign busy    = (state_q == SPLIT);
  assign accept  = (wr | rd) & ~busy & ~reset;
  assign rd_data = DATA_W'(rd_data_q);

  always_comb begin
    k_cur      = addr[8:2];
    mask_cur   = lane_mask(funct3, addr[1:0]);
    split_cur  = |mask_cur[7:4];
    wdat64_cur = {32'b0, 32'(wr_data)} << {addr[1:0], 3'b000};
    rd_cur     = extend(window({32'b0, mem[k_cur]}, addr[1:0]), funct3);
    rd_split   = extend(window({mem[k1_q], lo_q}, off_q), funct3_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && split_cur) state_d = SPLIT;
      SPLIT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Storage is never reset; reset only suppresses writes in its cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int b = 0; b < 4; b++) begin
        if (accept && wr && mask_cur[b])
          mem[k_cur][8*b +: 8] <= wdat64_cur[8*b +: 8];
        if (busy && wr_q && mask_hi_q[b])
          mem[k1_q][8*b +: 8] <= wdat_hi_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && split_cur) begin
      k1_q      <= k_cur + 7'd1;
      off_q     <= addr[1:0];
      funct3_q  <= funct3;
      wdat_hi_q <= wdat64_cur[63:32];
      mask_hi_q <= mask_cur[7:4];
      wr_q      <= wr;
      rd_only_q <= rd & ~wr;
      lo_q      <= mem[k_cur];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_data_q <= '0;
      rd_valid  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_valid <= 1'b0;
      if (accept && rd && !wr && !split_cur) begin
        rd_data_q <= rd_cur;
        rd_valid  <= 1'b1;
      end
      if (busy && rd_only_q) begin
        rd_data_q <= rd_split;
        rd_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus pushes expected load results,
// a negedge monitor pops and checks data and arrival cycle on every rd_valid pulse.
module tb_data_mem_responder;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr;
  logic        rd;
  logic [8:0]  addr;
  logic [2:0]  funct3;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;

  data_mem_responder #(.DATA_W(32), .DEPTH_W(128)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .funct3(funct3),
    .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_data_q[$];
  int          exp_cyc_q[$];
  string       exp_name_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every rd_valid pulse must match the oldest outstanding load
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_data_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rd_valid: pulse at cycle %0d with rd_data 0x%08h, expected no pulse", cyc, rd_data);
      end else begin
        logic [31:0] d;
        int          at;
        string       nm;
        d  = exp_data_q.pop_front();
        at = exp_cyc_q.pop_front();
        nm = exp_name_q.pop_front();
        check({nm, "_data"}, rd_data, d);
        check({nm, "_latency"}, cyc, at);
      end
    end
  end

  // lat counts edges from acceptance to the edge that raises rd_valid, plus one
  task automatic issue(input logic w, input logic r, input logic [8:0] a, input logic [2:0] f,
                       input logic [31:0] d, input bit exp_rd, input logic [31:0] exp_d,
                       input int lat, input string name);
    @(negedge clk);
    wr = w; rd = r; addr = a; funct3 = f; wr_data = d;
    if (exp_rd) begin
      exp_data_q.push_back(exp_d);
      exp_cyc_q.push_back(cyc + lat);
      exp_name_q.push_back(name);
    end
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic store(input logic [8:0] a, input logic [2:0] f, input logic [31:0] d);
    issue(1'b1, 1'b0, a, f, d, 1'b0, 32'h0, 0, "store");
  endtask

  task automatic load(input logic [8:0] a, input logic [2:0] f, input logic [31:0] exp_d,
                      input int lat, input string name);
    issue(1'b0, 1'b1, a, f, 32'h0, 1'b1, exp_d, lat, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; funct3 = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_rd_valid", {31'b0, rd_valid}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;

    // Aligned word store and load
    store(9'h010, F_W, 32'hDEADBEEF);
    check("sw010_busy", {31'b0, busy}, 32'h0);
    load(9'h010, F_W, 32'hDEADBEEF, 1, "lw010");
    check("lw010_busy", {31'b0, busy}, 32'h0);

    // Byte store, signed and unsigned byte loads
    store(9'h013, F_B, 32'h00000080);
    load(9'h013, F_B, 32'hFFFFFF80, 1, "lb013");
    load(9'h013, F_BU, 32'h00000080, 1, "lbu013");

    // Word straddling words 1 and 2
    store(9'h004, F_W, 32'hCAFEBABE);
    store(9'h006, F_W, 32'h11223344);
    check("sw006_busy_set", {31'b0, busy}, 32'h1);
    @(negedge clk);
    check("sw006_busy_clear", {31'b0, busy}, 32'h0);
    load(9'h006, F_W, 32'h11223344, 2, "lw006");
    load(9'h004, F_W, 32'h3344BABE, 1, "lw004");

    // Half straddling the top of memory, wrapping to byte 0
    store(9'h1FF, F_H, 32'h0000A55A);
    load(9'h1FF, F_HU, 32'h0000A55A, 2, "lhu1ff");
    load(9'h1FF, F_BU, 32'h0000005A, 1, "lbu1ff");
    load(9'h000, F_BU, 32'h000000A5, 1, "lbu000");
    load(9'h1FF, F_H, 32'hFFFFA55A, 2, "lh1ff");

    // Aligned halves with sign extension
    store(9'h002, F_H, 32'h00008001);
    load(9'h002, F_H, 32'hFFFF8001, 1, "lh002");
    load(9'h002, F_HU, 32'h00008001, 1, "lhu002");

    // Reset during the second half of a straddling store aborts it
    store(9'h008, F_W, 32'h00000000);
    store(9'h00C, F_W, 32'h01020304);
    store(9'h00A, F_W, 32'hAABBCCDD);
    check("sw00a_busy_set", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_rd_valid", {31'b0, rd_valid}, 32'h0);
    reset = 1'b0;
    load(9'h00C, F_W, 32'h01020304, 1, "lw00c_after_abort");
    load(9'h008, F_W, 32'hCCDD0000, 1, "lw008_after_abort");

    // wr and rd together: write only, no pulse
    issue(1'b1, 1'b1, 9'h020, F_W, 32'h00000005, 1'b0, 32'h0, 0, "wrrd020");
    @(negedge clk);
    load(9'h020, F_W, 32'h00000005, 1, "lw020");

    // Request in a reset cycle is ignored, memory survives reset
    store(9'h030, F_W, 32'h12345678);
    @(negedge clk);
    reset = 1'b1; wr = 1'b1; addr = 9'h030; funct3 = F_W; wr_data = 32'hFFFFFFFF;
    @(negedge clk);
    reset = 1'b0; wr = 1'b0;
    load(9'h030, F_W, 32'h12345678, 1, "lw030_after_reset");
    repeat (2) @(negedge clk);
    check("rd_data_hold", rd_data, 32'h12345678);

    repeat (4) @(negedge clk);
    while (exp_data_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s_missing: no rd_valid pulse seen, expected 0x%08h at cycle %0d",
               exp_name_q[0], exp_data_q[0], exp_cyc_q[0]);
      void'(exp_data_q.pop_front());
      void'(exp_cyc_q.pop_front());
      void'(exp_name_q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
